// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;
    localparam logic [4:0]  REG_ZERO            = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    // Pipeline register controls, bundled so whole-pipeline patterns can be assigned at once.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                           idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1,
                                           memwb_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                           idex_we: 1'b0, idex_flush: 1'b0, exmem_we: 1'b0,
                                           memwb_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                           idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0,
                                           memwb_bubble: 1'b1};

    // True when the load in EX writes a register the ID instruction reads.
    function automatic logic load_use_match(
        input logic       ex_load,
        input logic [4:0] ex_dest,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_load && (ex_dest != REG_ZERO) &&
               ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall-cycle and branch-flush performance counters; both wrap silently.
module hazard_perf_counters #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_inc_i,
    input  logic                   flush_inc_i,
    output logic [COUNT_WIDTH-1:0] stall_count_o,
    output logic [COUNT_WIDTH-1:0] flush_count_o
);

    logic [COUNT_WIDTH-1:0] stall_q, stall_d;
    logic [COUNT_WIDTH-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc_i) stall_d = stall_q + COUNT_WIDTH'(1);
        if (flush_inc_i) flush_d = flush_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_count_o = stall_q;
    assign flush_count_o = flush_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits with timeout,
// load-use bubbles and taken-branch flushes, plus performance counters.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [4:0]             IDSourceRegister,
    input  logic [4:0]             IDTargetRegister,
    input  logic                   IDUsesTarget,
    input  logic                   EXMemoryReadEnable,
    input  logic [4:0]             EXDestinationRegister,
    input  logic                   BranchTaken,
    input  logic                   MEMAccessRequest,
    input  logic                   DataMemoryReady,
    output logic                   PCWriteEnable,
    output logic                   IFIDWriteEnable,
    output logic                   IFIDFlush,
    output logic                   IDEXWriteEnable,
    output logic                   IDEXFlush,
    output logic                   EXMEMWriteEnable,
    output logic                   MEMWBBubble,
    output logic                   MemoryTimeoutError,
    output logic [COUNT_WIDTH-1:0] StallCycleCount,
    output logic [COUNT_WIDTH-1:0] FlushCount
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    pipe_ctrl_t ctrl;
    logic       load_use;
    logic       eval_hazards;
    logic       drop_result;
    logic       branch_flush;

    assign load_use = load_use_match(EXMemoryReadEnable, EXDestinationRegister,
                                     IDSourceRegister, IDTargetRegister, IDUsesTarget);

    // Next-state and pipeline control decode; memory wait outranks branch, branch outranks load-use.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        ctrl          = CTRL_RUN;
        eval_hazards  = 1'b0;
        drop_result   = 1'b0;
        branch_flush  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MEMAccessRequest && !DataMemoryReady) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    eval_hazards = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (DataMemoryReady) begin
                    state_d      = RUN;
                    wait_cnt_d   = '0;
                    eval_hazards = 1'b1;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                    eval_hazards  = 1'b1;
                    drop_result   = 1'b1;
                end else begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Branch and load-use held behind a freeze are resolved on the release cycle.
        if (eval_hazards) begin
            if (BranchTaken) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                branch_flush    = 1'b1;
            end else if (load_use) begin
                ctrl.pc_we      = 1'b0;
                ctrl.ifid_we    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
        end

        if (drop_result) ctrl.memwb_bubble = 1'b1;

        if (!Reset) begin
            ctrl         = CTRL_RESET;
            branch_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    hazard_perf_counters #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_perf (
        .clk           (clk),
        .rst_n         (Reset),
        .stall_inc_i   (Reset && !ctrl.pc_we),
        .flush_inc_i   (branch_flush),
        .stall_count_o (StallCycleCount),
        .flush_count_o (FlushCount)
    );

    assign PCWriteEnable      = ctrl.pc_we;
    assign IFIDWriteEnable    = ctrl.ifid_we;
    assign IFIDFlush          = ctrl.ifid_flush;
    assign IDEXWriteEnable    = ctrl.idex_we;
    assign IDEXFlush          = ctrl.idex_flush;
    assign EXMEMWriteEnable   = ctrl.exmem_we;
    assign MEMWBBubble        = ctrl.memwb_bubble;
    assign MemoryTimeoutError = timeout_err_q;

endmodule
